// File: rtl/window_offset_pkg.sv
// window_offset_pkg: shared types, direction indices and raster defaults for the window offset engine
package window_offset_pkg;
    typedef enum logic [1:0] {WRAP, CLAMP, BOUNCE, WRAP_RSV} mode_t;
    typedef enum logic {IDLE, UPDATE} state_t;
    localparam int UP = 0;
    localparam int DOWN = 1;
    localparam int LEFT = 2;
    localparam int RIGHT = 3;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;
    localparam int DEF_WIN_W = 8;
    localparam int DEF_WIN_H = 16;
    function automatic int centre_start(input int res, input int win);
        return (res - win) / 2;
    endfunction
endpackage

// File: rtl/axis_offset_unit.sv
// axis_offset_unit: one axis of the window -- registered start, derived end, wrap/clamp/bounce stepping
module axis_offset_unit
    import window_offset_pkg::*;
#(
    parameter int RES = DEF_H_RES,
    parameter int WIN = DEF_WIN_W,
    parameter int UNIT = 8,
    parameter int W = 10,
    parameter int STEP_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              recenter,
    input  logic              load,
    input  logic              is_auto,
    input  logic [1:0]        mode,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    output logic [W-1:0]      pos_start,
    output logic [W-1:0]      pos_end,
    output logic              wrap_flag,
    output logic              hit_lo,
    output logic              hit_hi,
    output logic              bounce_swap
);
    localparam int EW = W + STEP_W;
    localparam logic [EW-1:0] RES_E = EW'(RES);
    localparam logic [EW-1:0] LIM = EW'(RES - WIN);
    localparam logic [W-1:0] CTR = W'(centre_start(RES, WIN));

    if (((1 << STEP_W) - 1) * UNIT >= RES) begin : g_step_range
        $error("maximum step distance must stay below the resolution");
    end

    logic [W-1:0] start_q;
    logic [EW-1:0] s, d, sc, sum, wrap_nxt, clamp_nxt, nxt, e;
    logic up, dn, clamp_md, hi, lo;

    always_comb begin
        s = EW'(start_q);
        d = EW'(step) * EW'(UNIT);
        up = inc & ~dec & (step != '0);
        dn = dec & ~inc & (step != '0);
        clamp_md = (mode == CLAMP) | (mode == BOUNCE);
        sc = (s > LIM) ? LIM : s;
        sum = s + d;
        wrap_nxt = up ? ((sum >= RES_E) ? sum - RES_E : sum) : dn ? ((d > s) ? s + RES_E - d : s - d) : s;
        hi = up & ((sc + d > LIM) | (sc == LIM));
        lo = dn & ((d > sc) | (sc == '0));
        clamp_nxt = hi ? LIM : lo ? '0 : up ? sc + d : dn ? sc - d : s;
        nxt = clamp_md ? clamp_nxt : wrap_nxt;
        e = s + EW'(WIN - 1);
        pos_start = start_q;
        pos_end = W'((e >= RES_E) ? e - RES_E : e);
        wrap_flag = pos_end < pos_start;
        bounce_swap = load & ~recenter & is_auto & (mode == BOUNCE) & (hi | lo);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q <= CTR;
            hit_lo <= 1'b0;
            hit_hi <= 1'b0;
        end else if (recenter) begin
            start_q <= CTR;
            hit_lo <= 1'b0;
            hit_hi <= 1'b0;
        end else if (load) begin
            start_q <= nxt[W-1:0];
            hit_lo <= clamp_md & lo;
            hit_hi <= clamp_md & hi;
        end else begin
            hit_lo <= 1'b0;
            hit_hi <= 1'b0;
        end
    end
endmodule

// File: rtl/window_offset_engine.sv
// window_offset_engine: move-command FSM, auto-move tick engine and two axis units tracking the drawable window
module window_offset_engine
    import window_offset_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES,
    parameter int WIN_W = DEF_WIN_W,
    parameter int WIN_H = DEF_WIN_H,
    parameter int UNIT_H = 8,
    parameter int UNIT_V = 16,
    parameter int STEP_W = 3,
    parameter int H_W = 10,
    parameter int V_W = 9,
    parameter int TICK_DIV = 1600000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              moveValid,
    output logic              moveReady,
    input  logic [3:0]        moveDirection,
    input  logic [STEP_W-1:0] moveStep,
    input  logic [1:0]        mode,
    input  logic              recenter,
    input  logic              autoEnable,
    input  logic [3:0]        autoDirInit,
    output logic [H_W-1:0]    posHorStart,
    output logic [H_W-1:0]    posHorEnd,
    output logic [V_W-1:0]    posVerStart,
    output logic [V_W-1:0]    posVerEnd,
    output logic [1:0]        wrapFlags,
    output logic [3:0]        edgeHit,
    output logic [3:0]        autoDir
);
    localparam int CW = $clog2(TICK_DIV);

    state_t state;
    logic [CW-1:0] tick_cnt;
    logic [3:0] dir_q, auto_dir_q;
    logic [STEP_W-1:0] step_q;
    logic [1:0] mode_q;
    logic auto_q, tick, accept, load, swap_h, swap_v, wrap_h, wrap_v;
    logic hit_l, hit_r, hit_u, hit_d;

    always_comb begin
        tick = autoEnable & (tick_cnt == CW'(TICK_DIV - 1));
        accept = moveValid & moveReady;
        load = state == UPDATE;
        autoDir = autoEnable ? auto_dir_q : autoDirInit;
        edgeHit = {hit_r, hit_l, hit_d, hit_u};
        wrapFlags = {wrap_h, wrap_v};
    end

    // a manual accept shadows a coincident tick; ticks seen outside IDLE are simply lost
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            moveReady <= 1'b1;
            dir_q <= '0;
            step_q <= '0;
            mode_q <= '0;
            auto_q <= 1'b0;
        end else if (recenter) begin
            state <= IDLE;
            moveReady <= 1'b1;
        end else if (state == IDLE && (accept || tick)) begin
            state <= UPDATE;
            moveReady <= 1'b0;
            dir_q <= accept ? moveDirection : auto_dir_q;
            step_q <= accept ? moveStep : STEP_W'(1);
            mode_q <= mode;
            auto_q <= ~accept;
        end else if (state == UPDATE) begin
            state <= IDLE;
            moveReady <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tick_cnt <= '0;
        else
            tick_cnt <= (recenter || !autoEnable || tick) ? '0 : tick_cnt + CW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            auto_dir_q <= '0;
        else if (!autoEnable)
            auto_dir_q <= autoDirInit;
        else if (swap_h || swap_v)
            auto_dir_q <= {swap_h ? {auto_dir_q[LEFT], auto_dir_q[RIGHT]} : auto_dir_q[RIGHT:LEFT],
                           swap_v ? {auto_dir_q[UP], auto_dir_q[DOWN]} : auto_dir_q[DOWN:UP]};
    end

    axis_offset_unit #(.RES(H_RES), .WIN(WIN_W), .UNIT(UNIT_H), .W(H_W), .STEP_W(STEP_W)) u_hor (
        .clock(clock), .reset(reset), .recenter(recenter), .load(load), .is_auto(auto_q), .mode(mode_q),
        .inc(dir_q[RIGHT]), .dec(dir_q[LEFT]), .step(step_q),
        .pos_start(posHorStart), .pos_end(posHorEnd), .wrap_flag(wrap_h),
        .hit_lo(hit_l), .hit_hi(hit_r), .bounce_swap(swap_h)
    );

    axis_offset_unit #(.RES(V_RES), .WIN(WIN_H), .UNIT(UNIT_V), .W(V_W), .STEP_W(STEP_W)) u_ver (
        .clock(clock), .reset(reset), .recenter(recenter), .load(load), .is_auto(auto_q), .mode(mode_q),
        .inc(dir_q[DOWN]), .dec(dir_q[UP]), .step(step_q),
        .pos_start(posVerStart), .pos_end(posVerEnd), .wrap_flag(wrap_v),
        .hit_lo(hit_u), .hit_hi(hit_d), .bounce_swap(swap_v)
    );
endmodule
